accu_avg_sink: RTL

- Downstream stage of the 4-sample accumulator.
- Consumes its 10-bit sums over a valid/ready handshake and buffers them in a small FIFO.
- Presents a rounded 8-bit per-sample average, the running peak sum, and a sample count to the next consumer over a second valid/ready handshake.
- Absorbs back-pressure so the accumulator stalls only when the buffer is full.

---
 rtl/accu_pkg.sv | 26 ++
 rtl/accu_sync_fifo.sv | 66 ++++++
 rtl/accu_avg_sink.sv | 90 +++++++++
 3 files changed

// File: rtl/accu_pkg.sv
// Shared constants for the accumulator / averaging sink pair.
package accu_pkg;

  // Width of the 4-sample sum produced by the accumulator.
  localparam int ACC_W = 10;

  // Width of the per-sample average handed downstream.
  localparam int AVG_W = 8;

  // Dividing by four with round-half-up: add half of the divisor, then shift.
  localparam int ROUND_BIAS = 2;
  localparam int AVG_SHIFT  = 2;

  // Largest average that fits in AVG_W bits.
  localparam int AVG_MAX = 255;

  // Default buffer depth and the pointer width it implies.
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  // Pointer width for an arbitrary power-of-two depth (at least one bit).
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/accu_sync_fifo.sv
// Small synchronous FIFO with registered occupancy and a combinational head word.
// Pushes while full and pops while empty are ignored, so callers may present
// raw requests without pre-gating.
module accu_sync_fifo
  import accu_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = ptrWidth(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_STEP   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_STEP   = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rdPtr];

  // Storage is not reset; only words that were actually pushed are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers wrap naturally; occupancy only moves when exactly one side fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_STEP;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_STEP;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_STEP;
        2'b01:   r_count <= r_count - CNT_STEP;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/accu_avg_sink.sv
// Downstream stage of the 4-sample accumulator: buffers incoming sums and
// presents a rounded per-sample average, the running peak sum and a pop count.
module accu_avg_sink #(
  parameter int DEPTH  = accu_pkg::FIFO_DEPTH,
  parameter int DATA_W = accu_pkg::ACC_W,
  parameter int AVG_W  = accu_pkg::AVG_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_a,
  output logic              ready_a,
  output logic              valid_b,
  input  logic              ready_b,
  output logic [AVG_W-1:0]  avg_out,
  output logic [DATA_W-1:0] peak_out,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam int                AVG_LIMIT = (1 << AVG_W) - 1;
  localparam logic [DATA_W:0]   BIAS      = (DATA_W+1)'(accu_pkg::ROUND_BIAS);
  localparam logic [DATA_W:0]   SAT_LEVEL = (DATA_W+1)'(AVG_LIMIT);
  localparam logic [AVG_W-1:0]  AVG_CAP   = AVG_W'(AVG_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_STEP  = CNT_W'(1);

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W:0]   w_rounded;
  logic [DATA_W-1:0] w_peakNow;
  logic [DATA_W-1:0] r_peak;
  logic [CNT_W-1:0]  r_sampleCnt;

  // Both handshakes depend only on registered occupancy, so there is no
  // combinational path from ready_b to ready_a and no full/empty bypass.
  assign ready_a = ~w_full;
  assign valid_b = ~w_empty;
  assign w_push  = valid_a & ready_a;
  assign w_pop   = valid_b & ready_b;

  accu_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (data_in),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // One extra bit keeps the rounding carry so a near-full-scale head saturates
  // instead of wrapping to zero.
  assign w_rounded = ({1'b0, w_head} + BIAS) >> accu_pkg::AVG_SHIFT;

  // Average of the head word; forced to zero while the buffer is empty.
  always_comb begin
    avg_out = '0;
    if (valid_b) begin
      if (w_rounded > SAT_LEVEL) begin
        avg_out = AVG_CAP;
      end else begin
        avg_out = w_rounded[AVG_W-1:0];
      end
    end
  end

  // The visible peak already accounts for the word waiting at the head.
  assign w_peakNow  = (w_head > r_peak) ? w_head : r_peak;
  assign peak_out   = valid_b ? w_peakNow : r_peak;
  assign sample_cnt = r_sampleCnt;

  // Peak and count are committed only when the consumer takes a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak      <= '0;
      r_sampleCnt <= '0;
    end else if (w_pop) begin
      r_peak      <= w_peakNow;
      r_sampleCnt <= r_sampleCnt + CNT_STEP;
    end
  end

endmodule
